// File: rtl/uart_loader.sv
// Serial program loader: receives an 0xA5-framed image over 8N1 UART and writes
// it word by word into RAM through the core's store-port encoding.
module uart_loader #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic [1:0]            weA,
    output logic [ADDR_WIDTH+1:0] addrA,
    output logic [31:0]           dinA,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam int AW   = ADDR_WIDTH + 2;

    // ---------------- RX front end ----------------
    logic          rx_s1, rx_s2, rx_prev;
    logic          rx_active;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          sample_tick;
    logic          rx_ferr;

    // rx_bit 0 is the start-bit recheck at CPB/2, 1..8 data, 9 stop
    assign sample_tick = rx_active &&
                         ((rx_bit == 4'd0) ? (rx_cnt == CW'(HALF)) : (rx_cnt == CW'(CPB)));
    assign rx_ferr     = sample_tick && (rx_bit == 4'd9) && !rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_active  <= 1'b0;
            rx_cnt     <= '0;
            rx_bit     <= 4'd0;
            rx_shift   <= 8'h00;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            if (!rx_active) begin
                if (rx_prev && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= CW'(1);
                    rx_bit    <= 4'd0;
                end
            end else if (sample_tick) begin
                rx_cnt <= CW'(1);
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s2)
                        rx_active <= 1'b0;
                end else if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    if (rx_s2) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= rx_shift;
                    end
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt + CW'(1);
            end
        end
    end

    // ---------------- Frame FSM ----------------
    typedef enum logic [1:0] {IDLE, ADDR, COUNT, DATA} state_t;

    state_t          state, state_n;
    logic [1:0]      byte_idx, idx_n;
    logic [31:0]     shreg, shreg_n;
    logic [31:0]     count, count_n;
    logic [31:0]     assembled;
    logic [AW-1:0]   addr_n;
    logic [1:0]      we_n;
    logic [31:0]     din_n;
    logic            busy_n, done_n, err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            shreg    <= 32'h0;
            count    <= 32'h0;
            weA      <= 2'b00;
            addrA    <= '0;
            dinA     <= 32'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            byte_idx <= idx_n;
            shreg    <= shreg_n;
            count    <= count_n;
            weA      <= we_n;
            addrA    <= addr_n;
            dinA     <= din_n;
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
        end
    end

    // Bytes arrive LSB first, so each new byte enters at the top of the word.
    always_comb begin
        state_n   = state;
        idx_n     = byte_idx;
        shreg_n   = shreg;
        count_n   = count;
        addr_n    = addrA;
        we_n      = 2'b00;
        din_n     = dinA;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = err;
        assembled = {rx_byte, shreg[31:8]};
        if (rx_ferr) begin
            err_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
        end else if (weA == 2'b11) begin
            // address advances after the write so addrA is stable during it
            addr_n  = addrA + AW'(4);
            count_n = count - 32'd1;
            if (count == 32'd1) begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        end else if (byte_valid) begin
            idx_n   = byte_idx + 2'd1;
            shreg_n = assembled;
            case (state)
                IDLE: begin
                    if (rx_byte == 8'hA5) begin
                        err_n   = 1'b0;
                        busy_n  = 1'b1;
                        idx_n   = 2'd0;
                        state_n = ADDR;
                    end
                end
                ADDR: begin
                    if (byte_idx == 2'd3) begin
                        addr_n  = {assembled[ADDR_WIDTH+1:2], 2'b00};
                        state_n = COUNT;
                    end
                end
                COUNT: begin
                    if (byte_idx == 2'd3) begin
                        count_n = assembled;
                        if (assembled == 32'd0) begin
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                        end
                    end
                end
                DATA: begin
                    if (byte_idx == 2'd3) begin
                        we_n  = 2'b11;
                        din_n = assembled;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: table of frames, hand-written corner sequences and
// random frames checked against an address/data reference model.
module tb_uart_loader;

    logic        clk;
    logic        rst;
    logic        uart_rx;
    logic [1:0]  weA;
    logic [14:0] addrA;
    logic [31:0] dinA;
    logic        busy, done, err;

    uart_loader #(.CLK_FREQ(1000), .BAUD_RATE(100), .ADDR_WIDTH(13)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .weA(weA), .addrA(addrA), .dinA(dinA),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: records every write and done pulse
    logic [14:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cnt = 0;
    int          done_busy = 0;
    int          last_done = 0;
    int          err_rise = 0;
    logic        err_q = 1'b0;
    logic        we_illegal = 1'b0;

    always @(negedge clk) begin
        if (weA == 2'b11) begin
            wr_addr.push_back(addrA);
            wr_data.push_back(dinA);
            wr_cyc.push_back(cyc);
        end
        if (weA != 2'b00 && weA != 2'b11) we_illegal <= 1'b1;
        if (done) begin
            done_cnt  <= done_cnt + 1;
            last_done <= cyc;
            if (busy) done_busy <= done_busy + 1;
        end
        if (err && !err_q) err_rise <= cyc;
        err_q <= err;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int          last_start = 0;
    logic [31:0] words[4];

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk); #1;
        last_start = cyc;
        uart_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (10) @(posedge clk); #1;
            uart_rx = b[i];
        end
        repeat (10) @(posedge clk); #1;
        uart_rx = stop;
        repeat (10) @(posedge clk); #1;
        uart_rx = 1'b1;
    endtask

    task automatic send_hdr(input logic [31:0] start, input logic [31:0] n);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(start[8*i +: 8], 1'b1);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b1);
    endtask

    task automatic send_frame(input logic [31:0] start, input logic [31:0] n, input int nw);
        send_hdr(start, n);
        for (int w = 0; w < nw; w++)
            for (int i = 0; i < 4; i++) send_byte(words[w][8*i +: 8], 1'b1);
    endtask

    // word i of a frame lands at word index (start/4 + i) mod RAM depth
    function automatic logic [14:0] model_addr(input logic [31:0] start, input int i);
        int unsigned wi;
        wi = ((start >> 2) + i) % 8192;
        return 15'(wi * 4);
    endfunction

    // compares writes recorded since 'base' against the model for nw words
    task automatic chk_writes(input string nm, input int base, input logic [31:0] start, input int nw);
        logic [14:0] aa;
        logic [31:0] ad;
        chk({nm, "_nwrites"}, 64'(wr_addr.size() - base), 64'(nw));
        for (int i = 0; i < nw; i++) begin
            aa = (base + i < wr_addr.size()) ? wr_addr[base + i] : 15'hx;
            ad = (base + i < wr_data.size()) ? wr_data[base + i] : 32'hx;
            chk({nm, "_addr"}, 64'(aa), 64'(model_addr(start, i)));
            chk({nm, "_data"}, 64'(ad), 64'(words[i]));
        end
    endtask

    typedef struct {
        logic [31:0] start;
        logic [31:0] n;
        logic [31:0] d0;
        logic [31:0] d1;
        int          nw;
        logic [14:0] a0;
        logic [14:0] a1;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base, dbase, dbusy, nn;
        logic [14:0] ea, aa;
        logic [31:0] ed, ad, st;
        logic [7:0]  nb;

        vecs[0] = '{32'h0000_0100, 32'd2, 32'h0000_0013, 32'h0000_006F, 2, 15'h0100, 15'h0104};
        vecs[1] = '{32'h0000_0103, 32'd0, 32'h0,         32'h0,         0, 15'h0000, 15'h0000};
        vecs[2] = '{32'h0000_0103, 32'd1, 32'h1122_3344, 32'h0,         1, 15'h0100, 15'h0000};
        vecs[3] = '{32'h0000_7FFC, 32'd2, 32'hA1B2_C3D4, 32'h55AA_55AA, 2, 15'h7FFC, 15'h0000};
        vecs[4] = '{32'hFFFF_0010, 32'd1, 32'h0BAD_C0DE, 32'h0,         1, 15'h0010, 15'h0000};

        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("reset_state", 64'({weA, addrA, dinA, busy, done, err}), 64'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // table-driven frames
        for (int v = 0; v < 5; v++) begin
            base = wr_addr.size(); dbase = done_cnt; dbusy = done_busy;
            words[0] = vecs[v].d0;
            words[1] = vecs[v].d1;
            send_frame(vecs[v].start, vecs[v].n, vecs[v].nw);
            repeat (20) @(posedge clk); #1;
            chk("vec_nwrites", 64'(wr_addr.size() - base), 64'(vecs[v].nw));
            for (int i = 0; i < vecs[v].nw; i++) begin
                ea = (i == 0) ? vecs[v].a0 : vecs[v].a1;
                ed = (i == 0) ? vecs[v].d0 : vecs[v].d1;
                aa = (base + i < wr_addr.size()) ? wr_addr[base + i] : 15'hx;
                ad = (base + i < wr_data.size()) ? wr_data[base + i] : 32'hx;
                chk("vec_addr", 64'(aa), 64'(ea));
                chk("vec_data", 64'(ad), 64'(ed));
            end
            chk("vec_done", 64'(done_cnt - dbase), 64'd1);
            chk("vec_done_busy_low", 64'(done_busy - dbusy), 64'd0);
            chk("vec_busy", 64'(busy), 64'd0);
            chk("vec_err", 64'(err), 64'd0);
            if (vecs[v].nw == 0) begin
                chk("vec_done_latency", 64'(last_done - last_start), 64'd99);
            end else begin
                nn = (wr_cyc.size() > base) ? wr_cyc[wr_cyc.size() - 1] : -1000;
                chk("vec_write_latency", 64'(nn - last_start), 64'd99);
                chk("vec_done_after_write", 64'(last_done - nn), 64'd1);
            end
        end

        // noise, then a 3-cycle glitch, then a valid frame
        base = wr_addr.size(); dbase = done_cnt;
        send_byte(8'h55, 1'b1);
        send_byte(8'hFF, 1'b1);
        @(posedge clk); #1; uart_rx = 1'b0;
        repeat (3) @(posedge clk); #1; uart_rx = 1'b1;
        repeat (30) @(posedge clk); #1;
        chk("noise_busy", 64'(busy), 64'd0);
        chk("noise_err", 64'(err), 64'd0);
        chk("noise_writes", 64'(wr_addr.size() - base), 64'd0);
        words[0] = 32'hCAFE_F00D;
        send_frame(32'h80, 32'd1, 1);
        repeat (20) @(posedge clk); #1;
        chk_writes("noise_frame", base, 32'h80, 1);
        chk("noise_frame_done", 64'(done_cnt - dbase), 64'd1);

        // framing error after one good word of two
        base = wr_addr.size(); dbase = done_cnt;
        send_byte(8'hA5, 1'b1);
        chk("magic_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            st = 32'h40;
            send_byte(st[8*i +: 8], 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            st = 32'd2;
            send_byte(st[8*i +: 8], 1'b1);
        end
        words[0] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) send_byte(words[0][8*i +: 8], 1'b1);
        send_byte(8'h12, 1'b0);
        repeat (20) @(posedge clk); #1;
        chk_writes("ferr", base, 32'h40, 1);
        chk("ferr_err", 64'(err), 64'd1);
        chk("ferr_busy", 64'(busy), 64'd0);
        chk("ferr_no_done", 64'(done_cnt - dbase), 64'd0);
        chk("ferr_err_latency", 64'(err_rise - last_start), 64'd98);
        send_byte(8'hA5, 1'b1);
        chk("ferr_cleared_by_magic", 64'(err), 64'd0);
        chk("ferr_magic_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) send_byte(8'h00, 1'b1);
        repeat (5) @(posedge clk); #1;
        chk("ferr_recover_done", 64'(done_cnt - dbase), 64'd1);

        // reset in the middle of the second data byte
        words[0] = 32'h0102_0304;
        send_hdr(32'h200, 32'd2);
        send_byte(words[0][7:0], 1'b1);
        fork
            send_byte(words[0][15:8], 1'b1);
            begin
                repeat (40) @(posedge clk); #3;
                rst = 1'b1;
                #1;
                chk("rst_async_clear", 64'({weA, addrA, dinA, busy, done, err}), 64'd0);
            end
        join
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        base = wr_addr.size(); dbase = done_cnt;
        words[0] = 32'h1357_9BDF;
        words[1] = 32'h2468_ACE0;
        send_frame(32'h300, 32'd2, 2);
        repeat (20) @(posedge clk); #1;
        chk_writes("post_rst", base, 32'h300, 2);
        chk("post_rst_done", 64'(done_cnt - dbase), 64'd1);

        // random frames with leading noise bytes
        for (int r = 0; r < 6; r++) begin
            base = wr_addr.size(); dbase = done_cnt;
            nn = $urandom_range(0, 2);
            for (int k = 0; k < nn; k++) begin
                nb = 8'($urandom_range(0, 255));
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb, 1'b1);
            end
            st = $urandom;
            nn = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) words[k] = $urandom;
            send_frame(st, 32'(nn), nn);
            repeat (20) @(posedge clk); #1;
            chk_writes("rand", base, st, nn);
            chk("rand_done", 64'(done_cnt - dbase), 64'd1);
            chk("rand_busy", 64'(busy), 64'd0);
        end

        chk("weA_encoding", 64'(we_illegal), 64'd0);
        chk("done_with_busy_low", 64'(done_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
